alu_arbiter: RTL and testbench

- Shares one 8-bit ALU datapath (sub, add, xor, shift-left) between two independent requesters.
- Each requester uses a valid/ready request channel. Results return on one shared response channel tagged with the requester id.
- Round-robin arbitration; a 3-state FSM sequences capture, execute and response.
- Sits between the two operand producers and the shared ALU.

---
 rtl/alu_arb_pkg.sv | 24 ++
 rtl/alu_core.sv | 53 +++++
 rtl/alu_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// ---------------------------------------------------------------------------
// alu_arb_pkg
//   Shared definitions for the two-requester ALU arbiter: the datapath width,
//   the ALU opcode constants and the sequencing FSM state encoding.
// ---------------------------------------------------------------------------
package alu_arb_pkg;

  // Operand/result width; the datapath is only built and checked for 8 bits.
  localparam int DATA_W = 8;

  // ALU opcodes as seen on reqN_op.
  localparam logic [1:0] OP_SUB = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_SHL = 2'b11;

  // Capture -> execute -> respond sequencing.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
//   Purely combinational shared ALU datapath.
//   Ports:
//     a_i, b_i  operands (DATA_W bits)
//     op_i      opcode (OP_SUB, OP_ADD, OP_XOR, OP_SHL)
//     result_o  result, modulo 2^DATA_W
//     flag_o    carry for add, borrow for sub, 0 for xor and shl
// ---------------------------------------------------------------------------
module alu_core
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [1:0]        op_i,
  output logic [DATA_W-1:0] result_o,
  output logic              flag_o
);

  logic [DATA_W:0] sumExt;
  logic [DATA_W:0] diffExt;

  // Both operands are zero-extended by one bit so the top bit of the sum is
  // the carry and the top bit of the difference is the borrow (set exactly
  // when a < b).
  assign sumExt  = {1'b0, a_i} + {1'b0, b_i};
  assign diffExt = {1'b0, a_i} - {1'b0, b_i};

  // Opcode select; shift-left ignores b and always reports flag 0.
  always_comb begin
    result_o = '0;
    flag_o   = 1'b0;
    case (op_i)
      OP_SUB: begin
        result_o = diffExt[DATA_W-1:0];
        flag_o   = diffExt[DATA_W];
      end
      OP_ADD: begin
        result_o = sumExt[DATA_W-1:0];
        flag_o   = sumExt[DATA_W];
      end
      OP_XOR: begin
        result_o = a_i ^ b_i;
      end
      default: begin
        result_o = {a_i[DATA_W-2:0], 1'b0};
      end
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one ALU (alu_core) between two valid/ready requesters with
//   round-robin arbitration. A request is captured in IDLE, computed in EXEC
//   and held on the shared response channel in RESP until taken.
//   Ports:
//     clk, rst_n                 clock (rising edge), async active-low reset
//     reqN_valid/reqN_ready      request handshake of requester N (0, 1)
//     reqN_a, reqN_b, reqN_op    operands and opcode of requester N
//     rsp_valid/rsp_ready        response handshake
//     rsp_id, rsp_result, rsp_flag  issuing requester, result, carry/borrow
//     busy                       FSM is not in IDLE
//   Optional build macro ALU_ARB_STATS_EN adds grant_cnt0/grant_cnt1, per
//   requester saturating counts of accepted handshakes.
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_flag,
  output logic              busy
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [7:0]        grant_cnt0,
  output logic [7:0]        grant_cnt1
`endif
);

  state_e            state_q, state_d;
  logic              rrPtr_q, rrPtr_d;
  logic [DATA_W-1:0] opA_q, opA_d;
  logic [DATA_W-1:0] opB_q, opB_d;
  logic [1:0]        op_q, op_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              flag_q, flag_d;
  logic              rspId_q, rspId_d;

  logic              grantId;
  logic              accept;
  logic [DATA_W-1:0] aluResult;
  logic              aluFlag;

  // The ALU only ever sees the captured operands, so request inputs may
  // change freely once the handshake has happened.
  alu_core #(
    .DATA_W (DATA_W)
  ) u_alu_core (
    .a_i      (opA_q),
    .b_i      (opB_q),
    .op_i     (op_q),
    .result_o (aluResult),
    .flag_o   (aluFlag)
  );

  // Grant selection: a lone requester always wins; on a tie the round-robin
  // pointer decides.
  always_comb begin
    grantId = 1'b0;
    if (req0_valid && req1_valid) begin
      grantId = rrPtr_q;
    end else if (req1_valid) begin
      grantId = 1'b1;
    end
  end

  assign req0_ready = (state_q == ST_IDLE) && req0_valid && !grantId;
  assign req1_ready = (state_q == ST_IDLE) && req1_valid && grantId;
  assign accept     = req0_ready || req1_ready;

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = rspId_q;
  assign rsp_result = result_q;
  assign rsp_flag   = flag_q;
  assign busy       = (state_q != ST_IDLE);

  // Next-state and register-update logic. The pointer only moves when a
  // response is consumed, and points away from the requester just served.
  always_comb begin
    state_d  = state_q;
    rrPtr_d  = rrPtr_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    op_d     = op_q;
    id_d     = id_q;
    result_d = result_q;
    flag_d   = flag_q;
    rspId_d  = rspId_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          opA_d   = grantId ? req1_a  : req0_a;
          opB_d   = grantId ? req1_b  : req0_b;
          op_d    = grantId ? req1_op : req0_op;
          id_d    = grantId;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        result_d = aluResult;
        flag_d   = aluFlag;
        rspId_d  = id_q;
        state_d  = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rrPtr_d = ~id_q;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rrPtr_q  <= RR_INIT;
      opA_q    <= '0;
      opB_q    <= '0;
      op_q     <= OP_SUB;
      id_q     <= 1'b0;
      result_q <= '0;
      flag_q   <= 1'b0;
      rspId_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rrPtr_q  <= rrPtr_d;
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      op_q     <= op_d;
      id_q     <= id_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      rspId_q  <= rspId_d;
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [7:0] grantCnt0_q, grantCnt0_d;
  logic [7:0] grantCnt1_q, grantCnt1_d;

  // Per-requester handshake counters that stick at 255 instead of wrapping.
  always_comb begin
    grantCnt0_d = grantCnt0_q;
    grantCnt1_d = grantCnt1_q;
    if (req0_ready && (grantCnt0_q != 8'hFF)) begin
      grantCnt0_d = grantCnt0_q + 8'd1;
    end
    if (req1_ready && (grantCnt1_q != 8'hFF)) begin
      grantCnt1_d = grantCnt1_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grantCnt0_q <= 8'd0;
      grantCnt1_q <= 8'd0;
    end else begin
      grantCnt0_q <= grantCnt0_d;
      grantCnt1_q <= grantCnt1_d;
    end
  end

  assign grant_cnt0 = grantCnt0_q;
  assign grant_cnt1 = grantCnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//   Self-checking bench for alu_arbiter (RR_INIT = 0). Directed cases from
//   the test plan followed by randomized transactions, all compared against
//   a transaction-level reference model of arbitration and arithmetic.
//   Define ALU_ARB_STATS_EN to also exercise the grant counters.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_flag, busy;
  logic [7:0] rsp_result;
`ifdef ALU_ARB_STATS_EN
  logic [7:0] grant_cnt0, grant_cnt1;
`endif

  int checkCount = 0;
  int failCount  = 0;
  int rrModel    = 0;
  int cntModel0  = 0;
  int cntModel1  = 0;

  alu_arbiter #(
    .DATA_W  (8),
    .RR_INIT (1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flag   (rsp_flag),
    .busy       (busy)
`ifdef ALU_ARB_STATS_EN
    ,
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against any hang so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts and reports every check.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference arithmetic with plain integers; returns flag*256 + result.
  function automatic int refAlu(input int op, input int a, input int b);
    int r;
    int f;
    r = 0;
    f = 0;
    case (op)
      0: begin r = (a - b + 256) % 256; f = (a < b) ? 1 : 0; end
      1: begin r = (a + b) % 256; f = (a + b >= 256) ? 1 : 0; end
      2: begin r = a ^ b; end
      default: begin r = (a * 2) % 256; end
    endcase
    return f * 256 + r;
  endfunction

  // Random noise on the request inputs while the arbiter is busy.
  task automatic driveNoise();
    req0_valid = 1'($urandom_range(0, 1));
    req1_valid = 1'($urandom_range(0, 1));
    req0_a     = 8'($urandom);
    req1_a     = 8'($urandom);
  endtask

  // One full transaction starting at a negedge in IDLE: present requests,
  // check the grant, follow EXEC and RESP (with `stall` backpressure cycles)
  // and return at the negedge after the response is consumed.
  task automatic applyStimulus(input bit v0, input logic [7:0] a0,
                               input logic [7:0] b0, input logic [1:0] op0,
                               input bit v1, input logic [7:0] a1,
                               input logic [7:0] b1, input logic [1:0] op1,
                               input int stall);
    int expGrant;
    int expRsp;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    rsp_ready  = 1'b0;
    #1;
    checkOutput("idleBusy", busy, 0);
    checkOutput("idleRspValid", rsp_valid, 0);
    if (!v0 && !v1) begin
      checkOutput("noReqReady0", req0_ready, 0);
      checkOutput("noReqReady1", req1_ready, 0);
      @(posedge clk);
      @(negedge clk);
      #1;
      checkOutput("noReqStayIdle", busy, 0);
      return;
    end
    expGrant = (v0 && v1) ? rrModel : (v1 ? 1 : 0);
    checkOutput("ready0", req0_ready, (v0 && expGrant == 0) ? 1 : 0);
    checkOutput("ready1", req1_ready, (v1 && expGrant == 1) ? 1 : 0);
    expRsp = (expGrant == 0) ? refAlu(int'(op0), int'(a0), int'(b0))
                             : refAlu(int'(op1), int'(a1), int'(b1));
    if (expGrant == 0) begin
      if (cntModel0 < 255) cntModel0++;
    end else begin
      if (cntModel1 < 255) cntModel1++;
    end
    @(posedge clk);
    @(negedge clk);
    driveNoise();
    #1;
    checkOutput("execBusy", busy, 1);
    checkOutput("execRspValid", rsp_valid, 0);
    checkOutput("execReady", {req0_ready, req1_ready}, 0);
    @(posedge clk);
    for (int i = 0; i <= stall; i++) begin
      @(negedge clk);
      driveNoise();
      rsp_ready = (i == stall);
      #1;
      checkOutput("rspValid", rsp_valid, 1);
      checkOutput("rspId", rsp_id, expGrant);
      checkOutput("rspResult", rsp_result, expRsp % 256);
      checkOutput("rspFlag", rsp_flag, expRsp / 256);
      checkOutput("rspBusy", busy, 1);
      checkOutput("rspReady", {req0_ready, req1_ready}, 0);
      @(posedge clk);
    end
    rrModel = 1 - expGrant;
    @(negedge clk);
    rsp_ready  = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    checkOutput("backIdleRspValid", rsp_valid, 0);
    checkOutput("backIdleBusy", busy, 0);
  endtask

  initial begin
    logic [7:0] ra0, rb0, ra1, rb1;
    logic [1:0] rop0, rop1;
    bit         rv0, rv1;

    rst_n      = 1'b0;
    rsp_ready  = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0;

    // Reset state.
    @(negedge clk);
    #1;
    checkOutput("resetRspValid", rsp_valid, 0);
    checkOutput("resetRspId", rsp_id, 0);
    checkOutput("resetRspResult", rsp_result, 0);
    checkOutput("resetRspFlag", rsp_flag, 0);
    checkOutput("resetBusy", busy, 0);
`ifdef ALU_ARB_STATS_EN
    checkOutput("resetCnt0", grant_cnt0, 0);
    checkOutput("resetCnt1", grant_cnt1, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed arithmetic cases.
    applyStimulus(1, 8'h05, 8'h03, 2'b01, 0, 8'h00, 8'h00, 2'b00, 0);
    applyStimulus(0, 8'h00, 8'h00, 2'b00, 1, 8'h03, 8'h05, 2'b00, 0);
    applyStimulus(1, 8'hFF, 8'h01, 2'b01, 0, 8'h00, 8'h00, 2'b00, 0);
    applyStimulus(0, 8'h00, 8'h00, 2'b00, 1, 8'h81, 8'h5A, 2'b11, 0);
    applyStimulus(1, 8'hF0, 8'hFF, 2'b10, 0, 8'h00, 8'h00, 2'b00, 0);
    applyStimulus(0, 8'h00, 8'h00, 2'b00, 0, 8'h00, 8'h00, 2'b00, 0);

    // Round-robin with both requesters held valid, then backpressure.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 8'h10 + 8'(i), 8'h01, 2'b01, 1, 8'h20, 8'h02, 2'b00, 0);
    end
    applyStimulus(1, 8'h7F, 8'h01, 2'b01, 1, 8'h0C, 8'h0A, 2'b10, 5);
    applyStimulus(1, 8'h01, 8'h02, 2'b00, 1, 8'h44, 8'h00, 2'b11, 0);

    // Reset during EXEC drops the operation and restores the pointer.
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 2'b01;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("midResetRspValid", rsp_valid, 0);
    checkOutput("midResetBusy", busy, 0);
    rrModel   = 0;
    cntModel0 = 0;
    cntModel1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("postResetNoRsp", rsp_valid, 0);
      checkOutput("postResetBusy", busy, 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 8'h30, 8'h31, 2'b00, 1, 8'h40, 8'h41, 2'b01, 0);
    end

    // Randomized traffic.
    for (int n = 0; n < 150; n++) begin
      rv0 = ($urandom_range(0, 3) != 0);
      rv1 = ($urandom_range(0, 3) != 0);
      ra0 = 8'($urandom); rb0 = 8'($urandom); rop0 = 2'($urandom);
      ra1 = 8'($urandom); rb1 = 8'($urandom); rop1 = 2'($urandom);
      applyStimulus(rv0, ra0, rb0, rop0, rv1, ra1, rb1, rop1,
                    int'($urandom_range(0, 3)));
    end

`ifdef ALU_ARB_STATS_EN
    checkOutput("cnt0Mid", grant_cnt0, cntModel0);
    checkOutput("cnt1Mid", grant_cnt1, cntModel1);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1, 8'($urandom), 8'($urandom), 2'($urandom),
                    0, 8'h00, 8'h00, 2'b00, 0);
    end
    checkOutput("cnt0Sat", grant_cnt0, 255);
    checkOutput("cnt1Held", grant_cnt1, cntModel1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             checkCount, failCount);
    $finish;
  end

endmodule
